sgpr_scoreboard: RTL and testbench

- Issue-side consumer of the SGPR write-retire interface (issue_alu_*, issue_lsu_*, issue_valu_*).
- Marks scalar registers busy when the issue stage dispatches an instruction that writes them. Clears them when the SGPR file reports the write retired.
- Answers registered RAW/WAW dependency checks for two source queries per cycle.
- Keeps per-wavefront outstanding-write counters so issue knows when a wavefront has no pending scalar writes.

---
 rtl/sgpr_scoreboard_pkg.sv | 43 ++++
 rtl/sgpr_scoreboard_if.sv | 52 +++++
 rtl/sgpr_sb_wf_counter.sv | 43 ++++
 rtl/sgpr_scoreboard.sv | 84 ++++++++
 tb/tb_sgpr_scoreboard.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sgpr_scoreboard_pkg.sv
// Shared constants, size encoding and mask helpers for the SGPR scoreboard.
// Register indices wrap modulo NUM_REGS; NUM_REGS must equal 2**ADDR_W.
package sgpr_scoreboard_pkg;

  localparam int NUM_REGS = 512;
  localparam int ADDR_W   = 9;
  localparam int NUM_WF   = 40;
  localparam int WFID_W   = 6;
  localparam int CNT_W    = 3;

  typedef enum logic [1:0] {
    SZ_1     = 2'b00,
    SZ_2     = 2'b01,
    SZ_4     = 2'b10,
    SZ_4_ALT = 2'b11
  } size_e;

  typedef logic [NUM_REGS-1:0] reg_mask_t;

  function automatic logic [3:0] size_to_valid(input logic [1:0] size);
    logic [3:0] valid;
    case (size)
      SZ_1:    valid = 4'b0001;
      SZ_2:    valid = 4'b0011;
      default: valid = 4'b1111;
    endcase
    return valid;
  endfunction

  // Bit k of valid marks base+k; the 9-bit add wraps 511+1 to 0 for free.
  function automatic reg_mask_t build_mask(input logic [ADDR_W-1:0] base,
                                           input logic [3:0]        valid);
    reg_mask_t         mask;
    logic [ADDR_W-1:0] idx;
    mask = '0;
    for (int k = 0; k < 4; k++) begin
      idx = base + ADDR_W'(k);
      if (valid[k]) mask[idx] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/sgpr_scoreboard_if.sv
// Issue/retire/query bundle between the issue stage and the SGPR scoreboard.
interface sgpr_scoreboard_if;
  import sgpr_scoreboard_pkg::*;

  logic                set_valid;
  logic [ADDR_W-1:0]   set_addr;
  logic [1:0]          set_size;
  logic [WFID_W-1:0]   set_wfid;

  logic                alu_wr_done;
  logic [WFID_W-1:0]   alu_wr_done_wfid;
  logic [ADDR_W-1:0]   alu_dest_reg_addr;
  logic [1:0]          alu_dest_reg_valid;

  logic                lsu_instr_done;
  logic [WFID_W-1:0]   lsu_instr_done_wfid;
  logic [ADDR_W-1:0]   lsu_dest_reg_addr;
  logic [3:0]          lsu_dest_reg_valid;

  logic                valu_dest_reg_valid;
  logic [ADDR_W-1:0]   valu_dest_addr;

  logic                chk0_valid, chk1_valid;
  logic [ADDR_W-1:0]   chk0_addr, chk1_addr;
  logic [1:0]          chk0_size, chk1_size;
  logic                chk0_rsp_valid, chk1_rsp_valid;
  logic                chk0_busy, chk1_busy;

  logic [NUM_WF-1:0]   wf_pending;
  logic                err_waw, err_spurious, err_overflow;

  modport master (
    output set_valid, set_addr, set_size, set_wfid,
           alu_wr_done, alu_wr_done_wfid, alu_dest_reg_addr, alu_dest_reg_valid,
           lsu_instr_done, lsu_instr_done_wfid, lsu_dest_reg_addr, lsu_dest_reg_valid,
           valu_dest_reg_valid, valu_dest_addr,
           chk0_valid, chk0_addr, chk0_size, chk1_valid, chk1_addr, chk1_size,
    input  chk0_rsp_valid, chk0_busy, chk1_rsp_valid, chk1_busy,
           wf_pending, err_waw, err_spurious, err_overflow
  );

  modport slave (
    input  set_valid, set_addr, set_size, set_wfid,
           alu_wr_done, alu_wr_done_wfid, alu_dest_reg_addr, alu_dest_reg_valid,
           lsu_instr_done, lsu_instr_done_wfid, lsu_dest_reg_addr, lsu_dest_reg_valid,
           valu_dest_reg_valid, valu_dest_addr,
           chk0_valid, chk0_addr, chk0_size, chk1_valid, chk1_addr, chk1_size,
    output chk0_rsp_valid, chk0_busy, chk1_rsp_valid, chk1_busy,
           wf_pending, err_waw, err_spurious, err_overflow
  );

endinterface

// File: rtl/sgpr_sb_wf_counter.sv
// Per-wavefront outstanding-write counter: +1 / -0..2 per cycle, saturating
// at both ends with one-cycle error strobes and a registered pending flag.
module sgpr_sb_wf_counter
  import sgpr_scoreboard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_i,
  input  logic [1:0] dec_i,
  output logic       pending_o,
  output logic       spurious_o,
  output logic       overflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q;
  logic [CNT_W+1:0] sum;

  // Two guard bits: top bit flags a negative result, bit CNT_W flags overflow.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch.
    sum        = {2'b00, cnt_q} + (CNT_W+2)'(inc_i) - (CNT_W+2)'(dec_i);
    spurious_o = sum[CNT_W+1];
    overflow_o = !sum[CNT_W+1] && sum[CNT_W];
    cnt_d      = sum[CNT_W-1:0];
    if (spurious_o)      cnt_d = '0;
    else if (overflow_o) cnt_d = '1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= |cnt_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/sgpr_scoreboard.sv
// SGPR busy-bit scoreboard with bypassed dependency queries and per-wavefront
// outstanding-write tracking.
module sgpr_scoreboard
  import sgpr_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  sgpr_scoreboard_if.slave   sb
);

  reg_mask_t busy_q, busy_d;
  reg_mask_t set_mask, clr_mask, live_mask;
  logic      chk0_hit, chk1_hit;
  logic      chk0_rsp_q, chk1_rsp_q, chk0_busy_q, chk1_busy_q;
  logic      err_waw_q, err_waw_d, err_spur_q, err_spur_d, err_ovf_q, err_ovf_d;

  logic [NUM_WF-1:0] wf_pend, wf_spur, wf_ovf;

  // live_mask is the busy vector after this cycle's retires; queries see it,
  // sets landing this cycle do not.
  always_comb begin
    set_mask  = sb.set_valid ? build_mask(sb.set_addr, size_to_valid(sb.set_size)) : '0;
    clr_mask  = build_mask(sb.alu_dest_reg_addr, {2'b00, sb.alu_dest_reg_valid})
              | build_mask(sb.lsu_dest_reg_addr, sb.lsu_dest_reg_valid)
              | build_mask(sb.valu_dest_addr, {2'b00, {2{sb.valu_dest_reg_valid}}});
    live_mask = busy_q & ~clr_mask;
    busy_d    = live_mask | set_mask;
    chk0_hit  = |(build_mask(sb.chk0_addr, size_to_valid(sb.chk0_size)) & live_mask);
    chk1_hit  = |(build_mask(sb.chk1_addr, size_to_valid(sb.chk1_size)) & live_mask);
    err_waw_d  = err_waw_q | (|(set_mask & live_mask));
    err_spur_d = err_spur_q | (|(clr_mask & ~busy_q & ~set_mask)) | (|wf_spur);
    err_ovf_d  = err_ovf_q | (|wf_ovf);
  end

  for (genvar w = 0; w < NUM_WF; w++) begin : g_wf
    logic       inc;
    logic [1:0] dec;
    assign inc = sb.set_valid && (sb.set_wfid == WFID_W'(w));
    assign dec = {1'b0, sb.alu_wr_done && (sb.alu_wr_done_wfid == WFID_W'(w))}
               + {1'b0, sb.lsu_instr_done && (sb.lsu_instr_done_wfid == WFID_W'(w))};

    sgpr_sb_wf_counter u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (inc),
      .dec_i      (dec),
      .pending_o  (wf_pend[w]),
      .spurious_o (wf_spur[w]),
      .overflow_o (wf_ovf[w])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      chk0_rsp_q  <= 1'b0;
      chk1_rsp_q  <= 1'b0;
      chk0_busy_q <= 1'b0;
      chk1_busy_q <= 1'b0;
      err_waw_q   <= 1'b0;
      err_spur_q  <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      chk0_rsp_q  <= sb.chk0_valid;
      chk1_rsp_q  <= sb.chk1_valid;
      chk0_busy_q <= sb.chk0_valid && chk0_hit;
      chk1_busy_q <= sb.chk1_valid && chk1_hit;
      err_waw_q   <= err_waw_d;
      err_spur_q  <= err_spur_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign sb.chk0_rsp_valid = chk0_rsp_q;
  assign sb.chk1_rsp_valid = chk1_rsp_q;
  assign sb.chk0_busy      = chk0_busy_q;
  assign sb.chk1_busy      = chk1_busy_q;
  assign sb.wf_pending     = wf_pend;
  assign sb.err_waw        = err_waw_q;
  assign sb.err_spurious   = err_spur_q;
  assign sb.err_overflow   = err_ovf_q;

endmodule

// File: tb/tb_sgpr_scoreboard.sv
// Self-checking bench for sgpr_scoreboard: directed scenarios plus randomized
// traffic compared against an array/integer reference model.
module tb_sgpr_scoreboard;
  import sgpr_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sgpr_scoreboard_if sb ();

  sgpr_scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  bit                m_busy [NUM_REGS];
  int                m_cnt  [NUM_WF];
  bit                m_waw, m_spur, m_ovf;
  bit                m_rsp0, m_hit0, m_rsp1, m_hit1;
  logic [NUM_WF-1:0] m_pend;

  function automatic int size_count(input logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  task automatic model_reset();
    foreach (m_busy[r]) m_busy[r] = 1'b0;
    foreach (m_cnt[w])  m_cnt[w]  = 0;
    m_waw = 0; m_spur = 0; m_ovf = 0;
    m_rsp0 = 0; m_hit0 = 0; m_rsp1 = 0; m_hit1 = 0;
    m_pend = '0;
  endtask

  // Advances the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit setm [NUM_REGS];
    bit clrm [NUM_REGS];
    bit hit;
    int a, v;
    foreach (setm[r]) begin setm[r] = 0; clrm[r] = 0; end
    if (sb.set_valid)
      for (int k = 0; k < size_count(sb.set_size); k++)
        setm[(int'(sb.set_addr) + k) % NUM_REGS] = 1;
    for (int k = 0; k < 2; k++)
      if (sb.alu_dest_reg_valid[k]) clrm[(int'(sb.alu_dest_reg_addr) + k) % NUM_REGS] = 1;
    for (int k = 0; k < 4; k++)
      if (sb.lsu_dest_reg_valid[k]) clrm[(int'(sb.lsu_dest_reg_addr) + k) % NUM_REGS] = 1;
    if (sb.valu_dest_reg_valid)
      for (int k = 0; k < 2; k++) clrm[(int'(sb.valu_dest_addr) + k) % NUM_REGS] = 1;

    hit = 0;
    for (int k = 0; k < size_count(sb.chk0_size); k++) begin
      a = (int'(sb.chk0_addr) + k) % NUM_REGS;
      if (m_busy[a] && !clrm[a]) hit = 1;
    end
    m_rsp0 = sb.chk0_valid;
    m_hit0 = sb.chk0_valid && hit;
    hit = 0;
    for (int k = 0; k < size_count(sb.chk1_size); k++) begin
      a = (int'(sb.chk1_addr) + k) % NUM_REGS;
      if (m_busy[a] && !clrm[a]) hit = 1;
    end
    m_rsp1 = sb.chk1_valid;
    m_hit1 = sb.chk1_valid && hit;

    for (int r = 0; r < NUM_REGS; r++) begin
      if (setm[r] && m_busy[r] && !clrm[r]) m_waw = 1;
      if (clrm[r] && !m_busy[r] && !setm[r]) m_spur = 1;
    end

    for (int w = 0; w < NUM_WF; w++) begin
      v = m_cnt[w];
      if (sb.set_valid && int'(sb.set_wfid) == w) v++;
      if (sb.alu_wr_done && int'(sb.alu_wr_done_wfid) == w) v--;
      if (sb.lsu_instr_done && int'(sb.lsu_instr_done_wfid) == w) v--;
      if (v < 0) begin m_spur = 1; v = 0; end
      if (v > (1 << CNT_W) - 1) begin m_ovf = 1; v = (1 << CNT_W) - 1; end
      m_cnt[w]  = v;
      m_pend[w] = (v != 0);
    end

    for (int r = 0; r < NUM_REGS; r++) m_busy[r] = setm[r] || (m_busy[r] && !clrm[r]);
  endtask

  task automatic idle();
    sb.set_valid = 0; sb.set_addr = '0; sb.set_size = '0; sb.set_wfid = '0;
    sb.alu_wr_done = 0; sb.alu_wr_done_wfid = '0; sb.alu_dest_reg_addr = '0; sb.alu_dest_reg_valid = '0;
    sb.lsu_instr_done = 0; sb.lsu_instr_done_wfid = '0; sb.lsu_dest_reg_addr = '0; sb.lsu_dest_reg_valid = '0;
    sb.valu_dest_reg_valid = 0; sb.valu_dest_addr = '0;
    sb.chk0_valid = 0; sb.chk0_addr = '0; sb.chk0_size = '0;
    sb.chk1_valid = 0; sb.chk1_addr = '0; sb.chk1_size = '0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({sb.chk0_rsp_valid, sb.chk0_busy, sb.chk1_rsp_valid, sb.chk1_busy} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_chk: got %b expected 0000",
        {sb.chk0_rsp_valid, sb.chk0_busy, sb.chk1_rsp_valid, sb.chk1_busy});
    end
    tests_run++;
    if (sb.wf_pending !== '0) begin
      tests_failed++; $display("FAIL reset_pending: got %h expected 0", sb.wf_pending);
    end
    tests_run++;
    if ({sb.err_waw, sb.err_spurious, sb.err_overflow} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_err: got %b expected 000",
        {sb.err_waw, sb.err_spurious, sb.err_overflow});
    end
    rst = 1'b0;
    model_reset();
    cycle();
  endtask

  task automatic test_basic();
    idle(); sb.set_valid = 1; sb.set_addr = 9'd100; sb.set_size = 2'b01; sb.set_wfid = 6'd3;
    cycle();
    idle(); sb.chk0_valid = 1; sb.chk0_addr = 9'd101; sb.chk0_size = 2'b00;
    cycle();
    tests_run++;
    if ({sb.chk0_rsp_valid, sb.chk0_busy} !== 2'b11) begin
      tests_failed++; $display("FAIL basic_busy: got %b expected 11", {sb.chk0_rsp_valid, sb.chk0_busy});
    end
    tests_run++;
    if (sb.wf_pending[3] !== 1'b1) begin
      tests_failed++; $display("FAIL basic_pending_set: got %b expected 1", sb.wf_pending[3]);
    end
    idle(); sb.alu_wr_done = 1; sb.alu_wr_done_wfid = 6'd3;
    sb.alu_dest_reg_addr = 9'd100; sb.alu_dest_reg_valid = 2'b11;
    cycle();
    idle(); sb.chk0_valid = 1; sb.chk0_addr = 9'd100; sb.chk0_size = 2'b01;
    cycle();
    tests_run++;
    if ({sb.chk0_rsp_valid, sb.chk0_busy} !== 2'b10) begin
      tests_failed++; $display("FAIL basic_clear: got %b expected 10", {sb.chk0_rsp_valid, sb.chk0_busy});
    end
    tests_run++;
    if (sb.wf_pending[3] !== 1'b0) begin
      tests_failed++; $display("FAIL basic_pending_clr: got %b expected 0", sb.wf_pending[3]);
    end
  endtask

  task automatic test_wrap();
    idle(); sb.set_valid = 1; sb.set_addr = 9'd510; sb.set_size = 2'b10; sb.set_wfid = 6'd7;
    cycle();
    idle(); sb.chk1_valid = 1; sb.chk1_addr = 9'd0; sb.chk1_size = 2'b00;
    sb.chk0_valid = 1; sb.chk0_addr = 9'd2; sb.chk0_size = 2'b00;
    cycle();
    tests_run++;
    if ({sb.chk1_rsp_valid, sb.chk1_busy} !== 2'b11) begin
      tests_failed++; $display("FAIL wrap_busy0: got %b expected 11", {sb.chk1_rsp_valid, sb.chk1_busy});
    end
    tests_run++;
    if ({sb.chk0_rsp_valid, sb.chk0_busy} !== 2'b10) begin
      tests_failed++; $display("FAIL wrap_idle2: got %b expected 10", {sb.chk0_rsp_valid, sb.chk0_busy});
    end
    idle(); sb.lsu_instr_done = 1; sb.lsu_instr_done_wfid = 6'd7;
    sb.lsu_dest_reg_addr = 9'd510; sb.lsu_dest_reg_valid = 4'b1111;
    cycle();
    idle(); sb.chk0_valid = 1; sb.chk0_addr = 9'd510; sb.chk0_size = 2'b10;
    cycle();
    tests_run++;
    if (sb.chk0_busy !== 1'b0) begin
      tests_failed++; $display("FAIL wrap_clear: got %b expected 0", sb.chk0_busy);
    end
    tests_run++;
    if (sb.err_spurious !== 1'b0) begin
      tests_failed++; $display("FAIL wrap_spurious: got %b expected 0", sb.err_spurious);
    end
  endtask

  task automatic test_same_cycle();
    idle(); sb.set_valid = 1; sb.set_addr = 9'd50; sb.set_size = 2'b00; sb.set_wfid = 6'd8;
    cycle();
    idle(); sb.set_valid = 1; sb.set_addr = 9'd50; sb.set_size = 2'b00; sb.set_wfid = 6'd8;
    sb.alu_wr_done = 1; sb.alu_wr_done_wfid = 6'd8;
    sb.alu_dest_reg_addr = 9'd50; sb.alu_dest_reg_valid = 2'b01;
    sb.chk0_valid = 1; sb.chk0_addr = 9'd50; sb.chk0_size = 2'b00;
    cycle();
    tests_run++;
    if ({sb.chk0_rsp_valid, sb.chk0_busy} !== 2'b10) begin
      tests_failed++; $display("FAIL same_bypass: got %b expected 10", {sb.chk0_rsp_valid, sb.chk0_busy});
    end
    tests_run++;
    if (sb.err_waw !== 1'b0) begin
      tests_failed++; $display("FAIL same_waw: got %b expected 0", sb.err_waw);
    end
    idle(); sb.chk0_valid = 1; sb.chk0_addr = 9'd50; sb.chk0_size = 2'b00;
    cycle();
    tests_run++;
    if (sb.chk0_busy !== 1'b1) begin
      tests_failed++; $display("FAIL same_set_wins: got %b expected 1", sb.chk0_busy);
    end
    idle(); sb.alu_wr_done = 1; sb.alu_wr_done_wfid = 6'd8;
    sb.alu_dest_reg_addr = 9'd50; sb.alu_dest_reg_valid = 2'b01;
    cycle();
    idle();
    cycle();
    tests_run++;
    if ({sb.err_spurious, sb.wf_pending[8]} !== 2'b00) begin
      tests_failed++; $display("FAIL same_cleanup: got %b expected 00", {sb.err_spurious, sb.wf_pending[8]});
    end
  endtask

  task automatic test_valu_spurious();
    idle(); sb.valu_dest_reg_valid = 1; sb.valu_dest_addr = 9'd200;
    cycle();
    tests_run++;
    if (sb.err_spurious !== 1'b1) begin
      tests_failed++; $display("FAIL valu_spurious: got %b expected 1", sb.err_spurious);
    end
    idle(); sb.set_valid = 1; sb.set_addr = 9'd210; sb.set_wfid = 6'd9;
    cycle();
    idle(); sb.alu_wr_done = 1; sb.alu_wr_done_wfid = 6'd9;
    sb.alu_dest_reg_addr = 9'd210; sb.alu_dest_reg_valid = 2'b01;
    cycle();
    idle();
    cycle();
    tests_run++;
    if ({sb.err_spurious, sb.err_waw} !== 2'b10) begin
      tests_failed++; $display("FAIL valu_sticky: got %b expected 10", {sb.err_spurious, sb.err_waw});
    end
  endtask

  task automatic test_counter_sat();
    tests_run++;
    if (sb.err_overflow !== 1'b0) begin
      tests_failed++; $display("FAIL sat_pre_ovf: got %b expected 0", sb.err_overflow);
    end
    for (int i = 0; i < 8; i++) begin
      idle(); sb.set_valid = 1; sb.set_addr = ADDR_W'(300 + 2 * i); sb.set_wfid = 6'd5;
      cycle();
    end
    idle();
    tests_run++;
    if ({sb.err_overflow, sb.wf_pending[5]} !== 2'b11) begin
      tests_failed++; $display("FAIL sat_overflow: got %b expected 11", {sb.err_overflow, sb.wf_pending[5]});
    end
    sb.alu_wr_done = 1; sb.alu_wr_done_wfid = 6'd5;
    sb.lsu_instr_done = 1; sb.lsu_instr_done_wfid = 6'd5;
    cycle();
    idle(); sb.alu_wr_done = 1; sb.alu_wr_done_wfid = 6'd5;
    repeat (4) cycle();
    tests_run++;
    if (sb.wf_pending[5] !== 1'b1) begin
      tests_failed++; $display("FAIL sat_count_4: got %b expected 1", sb.wf_pending[5]);
    end
    cycle();
    idle();
    tests_run++;
    if (sb.wf_pending[5] !== 1'b0) begin
      tests_failed++; $display("FAIL sat_count_5: got %b expected 0", sb.wf_pending[5]);
    end
  endtask

  task automatic test_reset_mid();
    idle(); sb.set_valid = 1; sb.set_addr = 9'd20; sb.set_size = 2'b10; sb.set_wfid = 6'd1;
    cycle();
    idle(); sb.chk0_valid = 1; sb.chk0_addr = 9'd20; sb.chk0_size = 2'b00;
    cycle();
    tests_run++;
    if ({sb.chk0_rsp_valid, sb.chk0_busy, sb.wf_pending[1]} !== 3'b111) begin
      tests_failed++; $display("FAIL mid_pre: got %b expected 111",
        {sb.chk0_rsp_valid, sb.chk0_busy, sb.wf_pending[1]});
    end
    sb.set_valid = 1; sb.set_addr = 9'd40; sb.set_wfid = 6'd2;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({sb.chk0_rsp_valid, sb.chk0_busy, sb.chk1_rsp_valid, sb.chk1_busy,
         sb.err_waw, sb.err_spurious, sb.err_overflow} !== 7'b0 || sb.wf_pending !== '0) begin
      tests_failed++; $display("FAIL mid_async: got %b/%h expected all 0",
        {sb.chk0_rsp_valid, sb.chk0_busy, sb.err_waw, sb.err_spurious, sb.err_overflow}, sb.wf_pending);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    model_reset();
    cycle();
    tests_run++;
    if (sb.chk0_rsp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mid_no_rsp: got %b expected 0", sb.chk0_rsp_valid);
    end
    sb.chk0_valid = 1; sb.chk0_addr = 9'd20; sb.chk0_size = 2'b10;
    cycle();
    idle();
    tests_run++;
    if ({sb.chk0_rsp_valid, sb.chk0_busy} !== 2'b10) begin
      tests_failed++; $display("FAIL mid_dropped: got %b expected 10", {sb.chk0_rsp_valid, sb.chk0_busy});
    end
  endtask

  task automatic test_random();
    int wf_pool [6] = '{0, 1, 2, 39, 40, 41};
    for (int round = 0; round < 3; round++) begin
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      for (int c = 0; c < 120; c++) begin
        sb.set_valid = 1'($urandom_range(0, 1));
        sb.set_addr  = ADDR_W'((500 + $urandom_range(0, 20)) % NUM_REGS);
        sb.set_size  = 2'($urandom_range(0, 3));
        sb.set_wfid  = WFID_W'(wf_pool[$urandom_range(0, 5)]);
        sb.alu_wr_done        = ($urandom_range(0, 2) == 0);
        sb.alu_wr_done_wfid   = WFID_W'(wf_pool[$urandom_range(0, 5)]);
        sb.alu_dest_reg_addr  = ADDR_W'((500 + $urandom_range(0, 20)) % NUM_REGS);
        sb.alu_dest_reg_valid = ($urandom_range(0, 1) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
        sb.lsu_instr_done      = ($urandom_range(0, 2) == 0);
        sb.lsu_instr_done_wfid = WFID_W'(wf_pool[$urandom_range(0, 5)]);
        sb.lsu_dest_reg_addr   = ADDR_W'((500 + $urandom_range(0, 20)) % NUM_REGS);
        sb.lsu_dest_reg_valid  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
        sb.valu_dest_reg_valid = ($urandom_range(0, 7) == 0);
        sb.valu_dest_addr      = ADDR_W'((500 + $urandom_range(0, 20)) % NUM_REGS);
        sb.chk0_valid = 1'($urandom_range(0, 1));
        sb.chk0_addr  = ADDR_W'((500 + $urandom_range(0, 20)) % NUM_REGS);
        sb.chk0_size  = 2'($urandom_range(0, 3));
        sb.chk1_valid = 1'($urandom_range(0, 1));
        sb.chk1_addr  = ADDR_W'((500 + $urandom_range(0, 20)) % NUM_REGS);
        sb.chk1_size  = 2'($urandom_range(0, 3));
        cycle();
        tests_run++;
        if ({sb.chk0_rsp_valid, sb.chk0_busy, sb.chk1_rsp_valid, sb.chk1_busy} !==
            {m_rsp0, m_hit0, m_rsp1, m_hit1}) begin
          tests_failed++; $display("FAIL rand_chk r%0d c%0d: got %b expected %b", round, c,
            {sb.chk0_rsp_valid, sb.chk0_busy, sb.chk1_rsp_valid, sb.chk1_busy},
            {m_rsp0, m_hit0, m_rsp1, m_hit1});
        end
        tests_run++;
        if (sb.wf_pending !== m_pend) begin
          tests_failed++; $display("FAIL rand_pending r%0d c%0d: got %h expected %h",
            round, c, sb.wf_pending, m_pend);
        end
        tests_run++;
        if ({sb.err_waw, sb.err_spurious, sb.err_overflow} !== {m_waw, m_spur, m_ovf}) begin
          tests_failed++; $display("FAIL rand_err r%0d c%0d: got %b expected %b", round, c,
            {sb.err_waw, sb.err_spurious, sb.err_overflow}, {m_waw, m_spur, m_ovf});
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    test_reset();
    test_basic();
    test_wrap();
    test_same_cycle();
    test_valu_spurious();
    test_counter_sat();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
